// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops and a WIDTH-cycle shift-add multiply,
// with valid/ready handshakes on the operand and result sides.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zf,
    output logic             of,
    output logic             cf,
    output logic             err
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               zf_q, zf_d;
    logic               of_q, of_d;
    logic               cf_q, cf_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   res;
    logic               res_of;
    logic               res_cf;
    logic               res_err;
    logic [2*WIDTH-1:0] acc_next;
    logic               accept;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};
    assign shamt  = b[SHW-1:0];

    // Single-cycle result path, evaluated straight from the live operands on accept.
    always_comb begin
        res     = '0;
        res_of  = 1'b0;
        res_cf  = 1'b0;
        res_err = 1'b0;
        case (alu_op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_ADD: begin
                res    = sum_w[WIDTH-1:0];
                res_cf = sum_w[WIDTH];
                res_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res    = diff_w[WIDTH-1:0];
                res_cf = diff_w[WIDTH];
                res_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res[0] = $signed(a) < $signed(b);
            OP_SLTU: res[0] = a < b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $unsigned($signed(a) >>> shamt);
            OP_MUL:  res = '0;
            default: res_err = 1'b1;
        endcase
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        zf_d     = zf_q;
        of_d     = of_q;
        cf_d     = cf_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_BUSY: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                    f_d     = acc_next[WIDTH-1:0];
                    zf_d    = (acc_next[WIDTH-1:0] == '0);
                    of_d    = |acc_next[2*WIDTH-1:WIDTH];
                    cf_d    = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    if (alu_op == OP_MUL) begin
                        // Bit 0 of the multiplier is folded in on the accept edge so the
                        // product lands exactly WIDTH edges after acceptance.
                        state_d  = S_BUSY;
                        acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
                        mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
                        mplier_d = {1'b0, b[WIDTH-1:1]};
                        cnt_d    = SHW'(WIDTH-1);
                    end else begin
                        state_d = S_DONE;
                        f_d     = res;
                        zf_d    = (res == '0);
                        of_d    = res_of;
                        cf_d    = res_cf;
                        err_d   = res_err;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            f_q      <= '0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
            cf_q     <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            zf_q     <= zf_d;
            of_q     <= of_d;
            cf_q     <= cf_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign f         = f_q;
    assign zf        = zf_q;
    assign of        = of_q;
    assign cf        = cf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed checks of alu_mc against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f;
    logic        zf;
    logic        of;
    logic        cf;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .zf(zf), .of(of), .cf(cf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rf, output logic rz, output logic ro,
                                  output logic rc, output logic re);
        longint      sx;
        longint      sy;
        longint      ls;
        int          ix;
        int          amt;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] wide;
        ix  = x;
        sx  = ix;
        ix  = y;
        sy  = ix;
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        amt = int'(y[4:0]);
        rf  = 32'd0;
        ro  = 1'b0;
        rc  = 1'b0;
        re  = 1'b0;
        case (op)
            4'd0:  rf = x & y;
            4'd1:  rf = x | y;
            4'd2:  rf = x ^ y;
            4'd3:  rf = ~(x | y);
            4'd4: begin
                wide = ux + uy;
                rf   = wide[31:0];
                rc   = wide > 64'hFFFF_FFFF;
                ls   = sx + sy;
                ro   = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
            end
            4'd5: begin
                rf = x - y;
                rc = x < y;
                ls = sx - sy;
                ro = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
            end
            4'd6:  rf = (sx < sy) ? 32'd1 : 32'd0;
            4'd7:  rf = (x < y) ? 32'd1 : 32'd0;
            4'd8:  rf = x << amt;
            4'd9:  rf = x >> amt;
            4'd10: begin
                ix = x;
                ix = ix >>> amt;
                rf = ix;
            end
            4'd11: begin
                wide = ux * uy;
                rf   = wide[31:0];
                ro   = wide[63:32] != 32'd0;
            end
            default: re = 1'b1;
        endcase
        rz = (rf == 32'd0);
    endfunction

    task automatic check_result(input string tag, input logic [3:0] op,
                                input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ef;
        logic ez, eo, ec, ee;
        model(op, x, y, ef, ez, eo, ec, ee);
        check({tag, ".out_valid"}, out_valid, 1'b1);
        check({tag, ".f"},   f,   ef);
        check({tag, ".zf"},  zf,  ez);
        check({tag, ".of"},  of,  eo);
        check({tag, ".cf"},  cf,  ec);
        check({tag, ".err"}, err, ee);
        $display("%s op=%0d a=%08h b=%08h -> f=%08h zf=%0b of=%0b cf=%0b err=%0b (model f=%08h)",
                 tag, op, x, y, f, zf, of, cf, err, ef);
    endtask

    // Issue one op from IDLE, wait for the result with out_ready low, check it, then drain.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] x, input logic [31:0] y);
        int   lat;
        int   exp_lat;
        logic busy_rdy;
        exp_lat = (op == 4'd11) ? 32 : 1;
        @(negedge clk);
        in_valid  = 1'b1;
        alu_op    = op;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        alu_op   = 4'($urandom_range(0, 15));
        lat      = 1;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 100) begin
            busy_rdy = busy_rdy | in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_in_ready"}, busy_rdy, 1'b0);
        check_result(tag, op, x, y);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".drained"}, out_valid, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alu_op    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.in_ready", in_ready, 1'b0);
        check("reset.flags", {f, zf, of, cf, err}, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset.in_ready", in_ready, 1'b1);

        run_op("add_ovf",  4'd4,  32'h7FFF_FFFF, 32'h1);
        run_op("sub_brw",  4'd5,  32'h0,         32'h1);
        run_op("slt",      4'd6,  32'hFFFF_FFFF, 32'h1);
        run_op("sltu",     4'd7,  32'hFFFF_FFFF, 32'h1);
        run_op("sra",      4'd10, 32'h8000_0000, 32'h24);
        run_op("sll0",     4'd8,  32'hDEAD_BEEF, 32'h0);
        run_op("illegal",  4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("mul_hi",   4'd11, 32'h0001_0000, 32'h0001_0000);
        run_op("add_cry",  4'd4,  32'hFFFF_FFFF, 32'h2);

        // Held result: no new accept while out_ready is low, then same-edge handoff.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd4; a = 32'd10; b = 32'd20; out_ready = 1'b0;
        @(posedge clk);
        #1;
        alu_op = 4'd2; a = 32'h55; b = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            check("hold.f", f, 32'd30);
            check("hold.out_valid", out_valid, 1'b1);
            check("hold.in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        $display("hold f=%08h out_valid=%0b in_ready=%0b", f, out_valid, in_ready);
        @(negedge clk);
        out_ready = 1'b1; alu_op = 4'd5; a = 32'd100; b = 32'd1;
        #1;
        check("handoff.in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_result("handoff", 4'd5, 32'd100, 32'd1);
        @(posedge clk);
        #1;
        check("handoff.drained", out_valid, 1'b0);

        // Back-to-back single-cycle ops: one result per cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 14));
            if (op == 4'd11) op = 4'd15;
            x = $urandom;
            y = $urandom;
            in_valid = 1'b1; out_ready = 1'b1; alu_op = op; a = x; b = y;
            @(posedge clk);
            #1;
            check_result("b2b", op, x, y);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b.drained", out_valid, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;

        // Randomised single transactions, including MUL and illegal opcodes.
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            if (i % 4 == 1) x = 32'($urandom_range(0, 3));
            if (i % 4 == 2) y = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            if (i % 5 == 3) x = 32'h8000_0000;
            run_op("rand", op, x, y);
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'd11; a = $urandom; b = $urandom;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midmul_rst.out_valid", out_valid, 1'b0);
        check("midmul_rst.outputs", {f, zf, of, cf, err}, 36'd0);
        check("midmul_rst.in_ready", in_ready, 1'b0);
        $display("midmul reset out_valid=%0b f=%08h in_ready=%0b", out_valid, f, in_ready);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst.in_ready", in_ready, 1'b1);
        run_op("add_after_rst", 4'd4, 32'd2, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
